// File: rtl/uart_pkg.sv
// Shared constants, state encoding and helpers for the UART line receiver.
package uart_pkg;

   localparam int unsigned OVERSAMPLE = 16;
   localparam logic [7:0]  ASCII_LF   = 8'h0A;
   localparam logic [7:0]  ASCII_CR   = 8'h0D;

   localparam int unsigned             HELLO_LEN   = 10;
   localparam logic [8*HELLO_LEN-1:0]  HELLO_WORLD = "HelloWorld";

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_BREAK
   } rx_state_e;

   // Byte idx of "HelloWorld" (first character at index 0); 0 beyond the end.
   function automatic logic [7:0] hello_byte(input logic [4:0] idx);
      logic [7:0]  b;
      int unsigned pos;
      b   = 8'h00;
      pos = 0;
      if (32'(idx) < HELLO_LEN) begin
         pos = 8 * (HELLO_LEN - 1 - 32'(idx));
         b   = HELLO_WORLD[pos +: 8];
      end
      return b;
   endfunction

   // Two-of-three vote used for noise-tolerant bit sampling.
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_os.sv
// 16x oversampling 8N1 byte receiver with input synchronizer.
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 50000000,
   parameter int unsigned BAUD_RATE = 9600
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int unsigned DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [1:0]       sync_q;
   logic             rx_s;
   logic             rx_prev;
   rx_state_e        state;
   logic [DIV_W-1:0] div_cnt;
   logic [3:0]       tick_cnt;
   logic [2:0]       bit_cnt;
   logic [1:0]       vote;
   logic [7:0]       shift_q;
   logic             tick_c;
   logic [4:0]       tick_num_c;
   logic             maj_c;

   assign rx_s       = sync_q[1];
   assign tick_c     = (div_cnt == DIV_W'(DIV - 1));
   assign tick_num_c = 5'(tick_cnt) + 5'd1;
   assign maj_c      = maj3(vote[0], vote[1], rx_s);

   // Two-flop synchronizer (idle-high reset) plus edge-detect history.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q  <= 2'b11;
         rx_prev <= 1'b1;
      end else begin
         sync_q  <= {sync_q[0], rx};
         rx_prev <= rx_s;
      end
   end

   // Byte FSM; ticks are numbered 1..16 within each bit period.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= RX_IDLE;
         div_cnt    <= '0;
         tick_cnt   <= '0;
         bit_cnt    <= '0;
         vote       <= '0;
         shift_q    <= '0;
         byte_data  <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (state != RX_IDLE) begin
            div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
            if (tick_c) tick_cnt <= tick_cnt + 4'd1;
         end
         case (state)
            RX_IDLE: begin
               div_cnt  <= '0;
               tick_cnt <= '0;
               if (rx_prev && !rx_s) state <= RX_START;
            end
            RX_START: begin
               if (tick_c) begin
                  if (tick_num_c == 5'd8 && rx_s) begin
                     state <= RX_IDLE;
                  end else if (tick_num_c == 5'(OVERSAMPLE)) begin
                     state   <= RX_DATA;
                     bit_cnt <= '0;
                  end
               end
            end
            RX_DATA: begin
               if (tick_c) begin
                  if (tick_num_c == 5'd7) vote[0] <= rx_s;
                  if (tick_num_c == 5'd8) vote[1] <= rx_s;
                  if (tick_num_c == 5'd9) shift_q <= {maj_c, shift_q[7:1]};
                  if (tick_num_c == 5'(OVERSAMPLE)) begin
                     if (bit_cnt == 3'd7) state <= RX_STOP;
                     else bit_cnt <= bit_cnt + 3'd1;
                  end
               end
            end
            RX_STOP: begin
               if (tick_c) begin
                  if (tick_num_c == 5'd7) vote[0] <= rx_s;
                  if (tick_num_c == 5'd8) vote[1] <= rx_s;
                  if (tick_num_c == 5'd9) begin
                     if (maj_c) begin
                        byte_data  <= shift_q;
                        byte_valid <= 1'b1;
                        state      <= RX_IDLE;
                     end else begin
                        frame_err <= 1'b1;
                        state     <= RX_BREAK;
                     end
                  end
               end
            end
            RX_BREAK: begin
               // Bad stop bit: wait for the line to return idle before rearming.
               if (rx_s) state <= RX_IDLE;
            end
            default: state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_line_rx.sv
// UART line assembler: collects bytes into a line buffer terminated by LF.
module uart_line_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 50000000,
   parameter int unsigned BAUD_RATE = 9600,
   parameter int unsigned MAX_LEN   = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic       line_valid,
   input  logic       line_ready,
   output logic [4:0] line_len,
   input  logic [3:0] rd_addr,
   output logic [7:0] rd_data,
   output logic       line_match,
   output logic       line_trunc,
   output logic       frame_err,
   output logic       drop_err
);

   localparam int unsigned LEN_W = 5;
   localparam int unsigned IDX_W = 4;

   logic [7:0]       byte_data;
   logic             byte_valid;
   logic [7:0]       buf_mem [MAX_LEN];
   logic [LEN_W-1:0] count;
   logic             trunc_q;
   logic             match_q;

   logic             hs_c;
   logic [LEN_W-1:0] cnt_base_c;
   logic             trunc_base_c;
   logic             match_base_c;
   logic             take_c;
   logic             is_lf_c;
   logic             is_cr_c;
   logic             wr_en_c;

   uart_rx_os #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD_RATE (BAUD_RATE)
   ) u_rx (
      .clk        (clk),
      .reset      (reset),
      .rx         (rx),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .frame_err  (frame_err)
   );

   // A handshake in the same cycle clears the line state before the byte lands.
   assign hs_c         = line_valid && line_ready;
   assign cnt_base_c   = hs_c ? '0 : count;
   assign trunc_base_c = hs_c ? 1'b0 : trunc_q;
   assign match_base_c = hs_c ? 1'b1 : match_q;
   assign take_c       = byte_valid && (!line_valid || hs_c);
   assign is_lf_c      = (byte_data == ASCII_LF);
   assign is_cr_c      = (byte_data == ASCII_CR);
   assign wr_en_c      = take_c && !is_lf_c && !is_cr_c
                         && (cnt_base_c < LEN_W'(MAX_LEN));

   // Line assembly, handshake and per-line status flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         line_valid <= 1'b0;
         line_len   <= '0;
         line_match <= 1'b0;
         line_trunc <= 1'b0;
         drop_err   <= 1'b0;
         count      <= '0;
         trunc_q    <= 1'b0;
         match_q    <= 1'b1;
      end else begin
         drop_err <= byte_valid && line_valid && !hs_c;
         if (hs_c) begin
            line_valid <= 1'b0;
            count      <= '0;
            trunc_q    <= 1'b0;
            match_q    <= 1'b1;
         end
         if (take_c) begin
            if (is_lf_c) begin
               if (cnt_base_c != '0) begin
                  line_valid <= 1'b1;
                  line_len   <= cnt_base_c;
                  line_match <= match_base_c && (cnt_base_c == LEN_W'(HELLO_LEN));
                  line_trunc <= trunc_base_c;
               end
            end else if (!is_cr_c) begin
               if (wr_en_c) begin
                  count   <= cnt_base_c + LEN_W'(1);
                  match_q <= match_base_c
                             && (cnt_base_c < LEN_W'(HELLO_LEN))
                             && (byte_data == hello_byte(cnt_base_c));
               end else begin
                  trunc_q <= 1'b1;
               end
            end
         end
      end
   end

   // Line buffer storage; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en_c) buf_mem[cnt_base_c[IDX_W-1:0]] <= byte_data;
   end

   // Registered read port.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_data <= '0;
      end else begin
         rd_data <= (32'(rd_addr) < MAX_LEN) ? buf_mem[rd_addr] : 8'h00;
      end
   end

endmodule

// File: doc/uart_line_rx.md
UART_LINE_RX -- requirements
Module: uart_line_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, serial bit rate.
REQ-003 SHALL have parameter MAX_LEN, default 16, line buffer depth in bytes.
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port rx  input  1  asynchronous serial input, 8N1, LSB first, idle high.
REQ-007 SHALL have port line_valid  output  1  a complete line is held for the consumer.
REQ-008 SHALL have port line_ready  input  1  consumer accepts the held line.
REQ-009 SHALL have port line_len  output  5  byte count of the held line, excluding terminator.
REQ-010 SHALL have port rd_addr  input  4  buffer read index.
REQ-011 SHALL have port rd_data  output  8  buffer byte at rd_addr, registered, 1-cycle latency.
REQ-012 SHALL have port line_match  output  1  held line equals "HelloWorld" (10 bytes).
REQ-013 SHALL have port line_trunc  output  1  held line lost bytes beyond MAX_LEN.
REQ-014 SHALL have port frame_err  output  1  one-cycle pulse per byte with bad stop bit.
REQ-015 SHALL have port drop_err  output  1  one-cycle pulse per byte discarded while a line is held.

Function
REQ-016 SHALL pass rx through a 2-flop synchronizer whose flops reset to 1.
REQ-017 SHALL generate an oversample tick every CLK_FREQ/(BAUD_RATE*16) clocks (325 at defaults, integer division).
REQ-018 SHALL run the byte FSM IDLE->START->DATA->STOP->IDLE at 16 ticks per bit.
REQ-019 IDLE SHALL move to START on a synchronized 1->0 transition and restart the tick count.
REQ-020 START SHALL sample at tick 8; low goes to DATA; high is a glitch and returns to IDLE with no error.
REQ-021 DATA SHALL take each bit as the majority of ticks 7, 8 and 9, shift LSB first, and count 8 bits.
REQ-022 STOP SHALL majority-sample; 1 accepts the byte; 0 pulses frame_err, discards the byte, and returns to IDLE only once synchronized rx is high.
REQ-023 An accepted 0x0D SHALL be ignored.
REQ-024 An accepted 0x0A with count>0 SHALL assert line_valid in the next cycle, with line_len=count.
REQ-025 An accepted 0x0A with count=0 SHALL be ignored.
REQ-026 Any other accepted byte SHALL be written at index count and increment count while count<MAX_LEN; otherwise it is dropped and the trunc flag set.
REQ-027 line_match SHALL be computed incrementally per byte and is 1 only if line_len=10 and all bytes match.
REQ-028 line_valid SHALL stay high, and line_len, line_match, line_trunc and the buffer SHALL stay frozen, until line_valid&&line_ready.
REQ-029 On handshake, the next cycle SHALL see line_valid=0, count=0, trunc=0 and match state re-armed.
REQ-030 A byte accepted while line_valid=1 and no handshake occurs SHALL be discarded with a drop_err pulse.
REQ-031 If handshake and byte acceptance coincide, the handshake SHALL apply first and the byte SHALL go to index 0 of the cleared buffer.
REQ-032 The serial FSM SHALL never stall waiting on line_ready.

Reset
REQ-033 While reset=0 the block SHALL hold line_valid=0, line_len=0, rd_data=0, line_match=0, line_trunc=0, frame_err=0, drop_err=0, FSM in IDLE, count=0 and tick counters at 0.
REQ-034 Reset asserted mid-byte or mid-line SHALL abandon the partial data with no error pulse.
REQ-035 Buffer contents need not be cleared.

Structure
REQ-036 Package uart_pkg SHALL hold OVERSAMPLE=16, ASCII_LF=8'h0A, ASCII_CR=8'h0D, and the 10-byte "HelloWorld" constant.
REQ-037 The byte receiver (REQ-016 to REQ-022) SHALL be the sub-module uart_rx_os, outputting byte, byte_valid and frame_err.
REQ-038 The line assembler SHALL be in uart_line_rx.

Verification
REQ-039 Send "HelloWorld\n" at 9600 baud -> line_valid=1, line_len=10, line_match=1; reading rd_addr 0..9 returns 0x48..0x64.
REQ-040 Send "Hello\r\n" -> line_len=5, line_match=0; the CR is not stored.
REQ-041 Send 20 x 0x41 then LF -> line_len=16, line_trunc=1.
REQ-042 Hold line_ready=0 and send "AB\n" then "C\n" -> the first line is retained and drop_err pulses twice.
REQ-043 Send a byte whose stop bit is 0 -> one frame_err pulse, no buffer write. Send a 3-tick low glitch -> no activity.
REQ-044 Assert reset mid-byte, then send "HelloWorld\n" -> clean reception with line_match=1.
